// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end for updown_counter: synchronise, debounce, decode x4 Gray
// transitions into step/dir pulses, and count illegal two-bit jumps.
`timescale 1ns/1ps
module quad_step_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ERR_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             dec_en,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  localparam logic [7:0]       DCNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  logic             r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic [1:0]       r_cand, r_stable;
  logic [7:0]       r_dcnt;
  state_t           r_state;
  logic             r_step, r_dir, r_err;
  logic [ERR_W-1:0] r_err_count;

  logic [1:0] w_code, w_fwd, w_rev;
  logic       w_accept;
  state_t     w_state_nxt;
  logic       w_step_nxt, w_dir_nxt, w_err_nxt, w_err_inc;

  assign w_code = {r_a_sync, r_b_sync};

  // While in INIT the settled code is taken even if it equals the reset value,
  // so an encoder resting at 00 still moves the block into TRACK.
  assign w_accept = (r_dcnt == DCNT_MAX) &&
                    ((r_state == ST_INIT) || (r_cand != r_stable));

  always_comb begin
    w_fwd = 2'b00;
    w_rev = 2'b00;
    case (r_stable)
      2'b00: begin w_fwd = 2'b01; w_rev = 2'b10; end
      2'b01: begin w_fwd = 2'b11; w_rev = 2'b00; end
      2'b11: begin w_fwd = 2'b10; w_rev = 2'b01; end
      default: begin w_fwd = 2'b00; w_rev = 2'b11; end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= quad_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= quad_b;
      r_b_sync <= r_b_meta;
    end
  end

  // Acceptance looks at the candidate held before this edge, so a code that
  // survived the full window is taken even if the pin moves on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cand   <= 2'b00;
      r_dcnt   <= 8'd0;
      r_stable <= 2'b00;
    end else begin
      if (w_code != r_cand) begin
        r_cand <= w_code;
        r_dcnt <= 8'd0;
      end else if (r_dcnt < DCNT_MAX) begin
        r_dcnt <= r_dcnt + 8'd1;
      end
      if (w_accept) begin
        r_stable <= r_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_INIT;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;
    w_err_inc   = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_INIT: begin
          w_state_nxt = ST_TRACK;
        end
        default: begin
          if (r_cand == w_fwd) begin
            w_step_nxt = dec_en;
            w_dir_nxt  = 1'b1;
          end else if (r_cand == w_rev) begin
            w_step_nxt = dec_en;
            w_dir_nxt  = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
            w_err_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_err_inc && (r_err_count != ERR_MAX)) begin
      r_err_count <= r_err_count + ERR_ONE;
    end
  end

  assign step      = r_step;
  assign dir       = r_dir;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: pin sequences with hand-computed step/err
// counts, latency, direction and error-counter values; a bench-side updown counter follows step/dir.
`timescale 1ns/1ps
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       dec_en = 1'b1;
  logic       err_clr = 1'b0;
  logic       step, dir, err;
  logic [7:0] err_count;

  int assertCount = 0;
  int failCount = 0;
  int cycle = 0;
  int stepCount = 0;
  int errPulses = 0;
  int counterValue = 0;
  int lastStepCycle = -1;
  int pinCycle = 0;
  int violations = 0;
  int s0, e0;
  logic prevStep = 1'b0, prevErr = 1'b0, prevDir = 1'b0;
  logic dirBeforeStep = 1'b0, dirAtStep = 1'b0;

  logic [1:0] fwdSeq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] revSeq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  quad_step_decoder #(.DEBOUNCE_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .rstn(rstn), .quad_a(quad_a), .quad_b(quad_b),
    .dec_en(dec_en), .err_clr(err_clr),
    .step(step), .dir(dir), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Observer acting as the downstream updown_counter, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (step) begin
      stepCount = stepCount + 1;
      lastStepCycle = cycle;
      dirBeforeStep = prevDir;
      dirAtStep = dir;
      counterValue = counterValue + (dir ? 1 : -1);
    end
    if (err) errPulses = errPulses + 1;
    if ((step && err) || (step && prevStep) || (err && prevErr)) violations = violations + 1;
    prevStep = step;
    prevErr = err;
    prevDir = dir;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount = assertCount + 1;
    if (observed !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] code, input int holdCycles);
    @(negedge clk);
    quad_a = code[1];
    quad_b = code[0];
    pinCycle = cycle;
    repeat (holdCycles - 1) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset step", step, 0);
    checkOutput("reset dir", dir, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset err_count", err_count, 0);
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("init silent steps", stepCount, 0);
    checkOutput("init silent errs", errPulses, 0);
    checkOutput("init dir", dir, 0);
    checkOutput("init err_count", err_count, 0);

    for (int i = 0; i < 4; i++) begin
      s0 = stepCount;
      applyStimulus(fwdSeq[i], 12);
      checkOutput("fwd step count", stepCount - s0, 1);
      checkOutput("fwd latency", lastStepCycle - pinCycle - 1, 6);
    end
    checkOutput("fwd dir", dir, 1);
    checkOutput("fwd counter", counterValue, 4);

    s0 = stepCount;
    for (int i = 0; i < 4; i++) applyStimulus(revSeq[i], 12);
    checkOutput("rev step count", stepCount - s0, 4);
    checkOutput("rev dir", dir, 0);
    checkOutput("rev counter", counterValue, 0);

    s0 = stepCount;
    applyStimulus(2'b01, 12);
    checkOutput("flip step count", stepCount - s0, 1);
    checkOutput("flip dir before", dirBeforeStep, 0);
    checkOutput("flip dir at step", dirAtStep, 1);
    applyStimulus(2'b00, 12);

    s0 = stepCount; e0 = errPulses;
    applyStimulus(2'b01, 3);
    applyStimulus(2'b00, 15);
    checkOutput("glitch3 steps", stepCount - s0, 0);
    checkOutput("glitch3 errs", errPulses - e0, 0);

    s0 = stepCount;
    applyStimulus(2'b01, 4);
    applyStimulus(2'b00, 4);
    checkOutput("pulse4 first step", stepCount - s0, 1);
    checkOutput("pulse4 first dir", dir, 1);
    repeat (12) @(negedge clk);
    checkOutput("pulse4 total steps", stepCount - s0, 2);
    checkOutput("pulse4 final dir", dir, 0);

    s0 = stepCount; e0 = errPulses;
    applyStimulus(2'b11, 10);
    checkOutput("illegal err pulses", errPulses - e0, 1);
    checkOutput("illegal steps", stepCount - s0, 0);
    checkOutput("illegal err_count", err_count, 1);
    checkOutput("illegal dir held", dir, 0);
    for (int i = 0; i < 300; i++) applyStimulus((i % 2 == 0) ? 2'b00 : 2'b11, 10);
    checkOutput("saturated err_count", err_count, 255);
    checkOutput("burst err pulses", errPulses - e0, 301);
    checkOutput("burst steps", stepCount - s0, 0);
    checkOutput("burst dir held", dir, 0);

    e0 = errPulses;
    @(negedge clk);
    quad_a = 1'b0;
    quad_b = 1'b0;
    repeat (6) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("clr with err pulse", errPulses - e0, 1);
    checkOutput("clr priority", err_count, 0);
    applyStimulus(2'b11, 10);
    checkOutput("count after clr", err_count, 1);

    dec_en = 1'b0;
    s0 = stepCount;
    applyStimulus(2'b10, 12);
    applyStimulus(2'b00, 12);
    applyStimulus(2'b01, 12);
    checkOutput("disabled steps", stepCount - s0, 0);
    checkOutput("disabled dir tracks", dir, 1);
    dec_en = 1'b1;
    s0 = stepCount;
    applyStimulus(2'b11, 12);
    checkOutput("reenabled steps", stepCount - s0, 1);
    checkOutput("reenabled dir", dirAtStep, 1);

    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midreset dir", dir, 0);
    checkOutput("midreset err_count", err_count, 0);
    checkOutput("midreset step", step, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    s0 = stepCount; e0 = errPulses;
    repeat (20) @(negedge clk);
    checkOutput("release steps", stepCount - s0, 0);
    checkOutput("release errs", errPulses - e0, 0);
    applyStimulus(2'b10, 12);
    checkOutput("post reset steps", stepCount - s0, 1);
    checkOutput("post reset dir", dir, 1);
    checkOutput("post reset latency", lastStepCycle - pinCycle - 1, 6);

    checkOutput("protocol violations", violations, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage of updown_counter: turns a two-phase quadrature input (rotary encoder or jog wheel, A/B) into the counter's enable/updown controls.
- Synchronises and debounces the asynchronous A/B pins.
- Decodes x4 Gray transitions into one-cycle step pulses plus a held direction.
- Counts illegal transitions for diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clk edges a synchronised A/B code must be stable before it is accepted (legal range 1..255).
- ERR_W, 8: width of the saturating illegal-transition counter.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- quad_a  input  1  phase A, asynchronous to clk.
- quad_b  input  1  phase B, asynchronous to clk.
- dec_en  input  1  1 = emit steps; 0 = keep tracking position code but suppress step pulses.
- err_clr  input  1  synchronous clear of err_count.
- step  output  1  one-cycle pulse per accepted legal transition; drives updown_counter.enable.
- dir  output  1  1 = forward/up, 0 = reverse/down; drives updown_counter.updown.
- err  output  1  one-cycle pulse per illegal transition.
- err_count  output  ERR_W  saturating count of illegal transitions.

Behaviour:
- Reset (rstn low, asynchronous): sync flops, candidate, stable code and debounce counter = 0; state = INIT; step = 0, dir = 0, err = 0, err_count = 0.
- Synchroniser: two-flop chain per phase, giving code s = {a_sync, b_sync}.
- Debounce:
  - If s != candidate: candidate <= s, dcnt <= 0.
  - Otherwise, if dcnt < DEBOUNCE_CYCLES-1: dcnt increments.
  - A code is accepted on the edge where dcnt == DEBOUNCE_CYCLES-1 and candidate != stable.
  - Any shorter excursion is discarded entirely.
- Latency: a pin change sampled at edge N gives step/err high for the cycle after edge N+2+DEBOUNCE_CYCLES. This is 6 edges at default.
- State INIT: the first accepted code loads stable silently (no step, no err); next state TRACK. This prevents a spurious step when the encoder rests at a non-00 position out of reset.
- State TRACK, forward Gray order 00 -> 01 -> 11 -> 10 -> 00:
  - Forward neighbour accepted: step = dec_en, dir <= 1.
  - Reverse neighbour accepted: step = dec_en, dir <= 0.
  - Both bits changed (00<->11, 01<->10): err = 1, step = 0, dir unchanged, err_count increments.
  - In every case stable <= accepted code; after an illegal jump the block resynchronises to the new position.
- dir updates in the same cycle step asserts and holds between steps. It is also updated while dec_en = 0.
- step and err are registered outputs, never high for more than one consecutive cycle per accepted code, and never both high.
- err_count:
  - Saturates at 2^ERR_W-1.
  - err_clr has priority over a simultaneous increment (result 0).
- Reset mid-operation: all state returns to reset values immediately; after release the block re-enters INIT, so the first code is again absorbed silently.

Test Plan:
- Reset, then hold A=B=0 for 50 cycles -> step never asserts; dir=0; err_count=0; state leaves INIT silently.
- Forward sequence 00,01,11,10,00, each held 12 cycles, dec_en=1, outputs wired to updown_counter starting at 0 -> exactly 4 step pulses, each 6 cycles after its pin change; dir=1; counter reads 4.
- Reverse sequence 00,10,11,01,00 from counter value 4 -> 4 pulses, dir=0, counter reads 0. Then one forward step -> dir flips to 1 in the same cycle as its pulse.
- Glitch: from stable 00, raise A for 3 cycles then return to 00 -> no step, no err. Raise A for 4+ cycles -> exactly one step, dir=1.
- Illegal: from 00 jump to 11, held 10 cycles -> err pulse once, step=0, err_count=1. Repeat 300 alternating 00/11 jumps -> err_count=255. Pulse err_clr in the same cycle as an err -> err_count=0.
- dec_en=0 during 3 forward steps, then re-enable and take 1 forward step -> no pulses while disabled; exactly 1 pulse after, decoded as forward. Assert rstn low mid-sequence at code 11 and release -> no step on release; the next forward step (11->10) produces exactly 1 pulse.
